ofmap_write_collector: RTL

OFMAP_WRITE_COLLECTOR -- requirements
Module: ofmap_write_collector

---
 rtl/ofmap_write_collector.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ofmap_write_collector.sv
// rtl/ofmap_write_collector.sv - show-ahead FIFO collecting post-unit results into output SRAM writes
module ofmap_write_collector #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_total_done,
  input  logic              clear,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] WC_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ENT_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, done_q;
  logic             full, pop, push, drop;
  logic [ENT_W-1:0] head;

  assign full     = (count_q == FULL_CNT);
  assign mem_wen  = (count_q != '0);
  // Head is forced to zero while empty so the SRAM port never shows stale entries.
  assign head      = mem_wen ? fifo_q[rd_ptr_q] : '0;
  assign mem_addr  = head[ENT_W-1:DATA_W];
  assign mem_wdata = head[DATA_W-1:0];

  assign pop  = mem_wen & mem_ready & ~clear;
  assign push = in_wen & ~clear & (~full | pop);
  assign drop = in_wen & ~clear & full & ~pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      word_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
        word_count_d = word_count_q + WC_ONE;
      end
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      if (drop) overflow_d = 1'b1;
    end
  end

  // Flush completes on the edge that empties the FIFO, provided no new word arrives.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_total_done) state_d = S_FLUSH;
                 else if (in_wen)   state_d = S_RUN;
        S_RUN:   if (in_total_done) state_d = S_FLUSH;
        S_FLUSH: if (count_d == '0 && !in_wen) state_d = S_DONE;
        S_DONE:  if (in_wen) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {in_addr, in_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      busy_q       <= (state_d == S_RUN) || (state_d == S_FLUSH);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule
